// File: rtl/csi_ctrl_pkg.sv
// csi_ctrl_pkg: clock-lane controller states and default word-clock timing
package csi_ctrl_pkg;
  typedef enum logic [3:0] {
    OFF, INIT, STOP, HS_REQ, HS_ON, HS_END, IDLE_ENT, IDLE, IDLE_EXIT,
    ULPS_ENT, ULPS, ULPS_EXIT, ULPS_WAIT, ERR
  } t_clk_ctrl_states;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int GAP_CYC_DEF = 8;
  localparam int WAKEUP_CYC_DEF = 1000;
  // States that wait on a PPI acknowledge and are therefore subject to the timeout
  function automatic logic is_wait(t_clk_ctrl_states s);
    return s inside {INIT, HS_REQ, HS_END, IDLE_ENT, IDLE_EXIT, ULPS_ENT, ULPS_WAIT};
  endfunction
endpackage

// File: rtl/csi_sat_cnt.sv
// csi_sat_cnt: clearable saturating up-counter with terminal-count compare
module csi_sat_cnt #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + 1'b1;
  assign tc = cnt >= term;
endmodule

// File: rtl/csi_clk_lane_ctrl.sv
// csi_clk_lane_ctrl: PPI-side sequencer for the D-PHY master clock lane
module csi_clk_lane_ctrl
  import csi_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int WAKEUP_CYC = WAKEUP_CYC_DEF,
  parameter int CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic lane_en,
  input  logic hs_req,
  input  logic idle_req,
  input  logic ulps_req,
  output logic clk_hs_rdy,
  output logic clk_idle,
  output logic clk_ulps,
  output logic err,
  output logic ppi_Enable,
  output logic ppi_TxRequestHS,
  output logic ppi_TxHSIdleClkHS,
  output logic ppi_TxUlpsClk,
  output logic ppi_TxUlpsExit,
  input  logic ppi_Stopstate,
  input  logic ppi_TxReadyHS,
  input  logic ppi_TxHSIdleClkReadyHS,
  input  logic ppi_UlpsActiveNot
);
  t_clk_ctrl_states state, nxt;
  logic [CNT_W-1:0] cnt, term;
  logic tc, gap_ok, bad;
  // The one counter serves as wakeup timer in ULPS_EXIT and as timeout everywhere else
  assign term = (state == ULPS_EXIT) ? CNT_W'(WAKEUP_CYC - 1) : CNT_W'(TIMEOUT_CYC - 1);
  assign gap_ok = cnt >= CNT_W'(GAP_CYC - 1);
  csi_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (nxt != state),
    .term(term),
    .cnt (cnt),
    .tc  (tc)
  );
  always_comb begin
    nxt = state;
    bad = 1'b0;
    case (state)
      OFF:       nxt = INIT;
      INIT:      nxt = ppi_Stopstate ? STOP : state;
      STOP: begin
        nxt = !gap_ok ? STOP : hs_req ? HS_REQ : ulps_req ? ULPS_ENT : STOP;
        bad = gap_ok && (idle_req || (hs_req && ulps_req));
      end
      HS_REQ:    nxt = ppi_TxReadyHS ? HS_ON : state;
      HS_ON:     nxt = !hs_req ? HS_END : idle_req ? IDLE_ENT : state;
      HS_END:    nxt = (!ppi_TxReadyHS && ppi_Stopstate) ? STOP : state;
      IDLE_ENT:  nxt = ppi_TxHSIdleClkReadyHS ? IDLE : state;
      IDLE:      nxt = !idle_req ? IDLE_EXIT : state;
      IDLE_EXIT: nxt = (!ppi_TxHSIdleClkReadyHS && ppi_TxReadyHS && gap_ok) ? HS_ON : state;
      ULPS_ENT:  nxt = !ppi_UlpsActiveNot ? ULPS : state;
      ULPS:      nxt = !ulps_req ? ULPS_EXIT : state;
      ULPS_EXIT: nxt = tc ? ULPS_WAIT : state;
      ULPS_WAIT: nxt = (ppi_Stopstate && ppi_UlpsActiveNot) ? STOP : state;
      default:   nxt = ERR;
    endcase
    if (nxt == state && tc && is_wait(state)) nxt = ERR;
    if (!lane_en) nxt = OFF;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state             <= OFF;
      err               <= 1'b0;
      ppi_Enable        <= 1'b0;
      ppi_TxRequestHS   <= 1'b0;
      ppi_TxHSIdleClkHS <= 1'b0;
      ppi_TxUlpsClk     <= 1'b0;
      ppi_TxUlpsExit    <= 1'b0;
      clk_hs_rdy        <= 1'b0;
      clk_idle          <= 1'b0;
      clk_ulps          <= 1'b0;
    end else begin
      state             <= nxt;
      err               <= err | (nxt == ERR) | (lane_en && bad);
      ppi_Enable        <= nxt != OFF;
      ppi_TxRequestHS   <= nxt inside {HS_REQ, HS_ON, IDLE_ENT, IDLE, IDLE_EXIT};
      ppi_TxHSIdleClkHS <= nxt inside {IDLE_ENT, IDLE};
      ppi_TxUlpsClk     <= nxt inside {ULPS_ENT, ULPS, ULPS_EXIT};
      ppi_TxUlpsExit    <= nxt == ULPS_EXIT;
      clk_hs_rdy        <= nxt == HS_ON;
      clk_idle          <= nxt == IDLE;
      clk_ulps          <= nxt == ULPS;
    end
endmodule

// File: tb/tb_csi_clk_lane_ctrl.sv
// tb_csi_clk_lane_ctrl: clock-lane controller against a latency-parameterised clock-lane PHY model
module tb_csi_clk_lane_ctrl;
  localparam int GAP = 8;
  localparam int WAKE = 1000;
  localparam int TMO = 4096;

  logic clk = 1'b0;
  logic rst, lane_en, hs_req, idle_req, ulps_req;
  logic clk_hs_rdy, clk_idle, clk_ulps, err;
  logic ppi_Enable, ppi_TxRequestHS, ppi_TxHSIdleClkHS, ppi_TxUlpsClk, ppi_TxUlpsExit;
  logic ppi_Stopstate = 1'b0, ppi_TxReadyHS = 1'b0, ppi_TxHSIdleClkReadyHS = 1'b0;
  logic ppi_UlpsActiveNot = 1'b1;

  always #5 clk = ~clk;

  csi_clk_lane_ctrl #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP), .WAKEUP_CYC(WAKE)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .lane_en               (lane_en),
    .hs_req                (hs_req),
    .idle_req              (idle_req),
    .ulps_req              (ulps_req),
    .clk_hs_rdy            (clk_hs_rdy),
    .clk_idle              (clk_idle),
    .clk_ulps              (clk_ulps),
    .err                   (err),
    .ppi_Enable            (ppi_Enable),
    .ppi_TxRequestHS       (ppi_TxRequestHS),
    .ppi_TxHSIdleClkHS     (ppi_TxHSIdleClkHS),
    .ppi_TxUlpsClk         (ppi_TxUlpsClk),
    .ppi_TxUlpsExit        (ppi_TxUlpsExit),
    .ppi_Stopstate         (ppi_Stopstate),
    .ppi_TxReadyHS         (ppi_TxReadyHS),
    .ppi_TxHSIdleClkReadyHS(ppi_TxHSIdleClkReadyHS),
    .ppi_UlpsActiveNot     (ppi_UlpsActiveNot)
  );

  // Observed vector: {err, clk_ulps, clk_idle, clk_hs_rdy, UlpsExit, UlpsClk, IdleClkHS, RequestHS, Enable}
  logic [8:0] obs;
  assign obs = {err, clk_ulps, clk_idle, clk_hs_rdy, ppi_TxUlpsExit, ppi_TxUlpsClk,
                ppi_TxHSIdleClkHS, ppi_TxRequestHS, ppi_Enable};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge timestamps (in clock-edge numbers) of every observed output
  int rise [9] = '{default: -1};
  int fall [9] = '{default: -1};
  logic [8:0] prev = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 9; i++)
      if (obs[i] !== prev[i]) begin
        if (obs[i] === 1'b1) rise[i] = cyc;
        else fall[i] = cyc;
      end
    prev = obs;
  end

  // Clock-lane PHY model: each acknowledge follows its request after lat cycles
  int lat = 2;
  logic tie_rdy0 = 1'b0;
  logic [4:0] hist [16] = '{default: '0};
  logic [4:0] h;
  always @(posedge clk) begin
    #1;
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {ppi_TxUlpsExit, ppi_TxUlpsClk, ppi_TxHSIdleClkHS, ppi_TxRequestHS, ppi_Enable};
    h = hist[lat-1];
    ppi_Stopstate = h[0] && !h[1] && !h[3];
    ppi_TxReadyHS = h[1] && !tie_rdy0;
    ppi_TxHSIdleClkReadyHS = h[2];
    ppi_UlpsActiveNot = !(h[3] && !h[4]);
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic le, input logic hs, input logic id, input logic ul);
    lane_en = le;
    hs_req = hs;
    idle_req = id;
    ulps_req = ul;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  typedef struct {
    logic le, hs, idle, ulps;
    int n;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, kind;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,    2, 9'b000000000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,   15, 9'b000000001};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,   10, 9'b000100011};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0,   10, 9'b001000111};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,   15, 9'b000100011};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,   15, 9'b000000001};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1,   10, 9'b010001001};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,   10, 9'b000011001};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1000, 9'b000000001};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0,   15, 9'b100000001};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0,   15, 9'b100100011};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0,    3, 9'b100000000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0,   15, 9'b100000001};
    set_in(0, 0, 0, 0);
    rst = 1'b0;
    #2 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].le, tbl[i].hs, tbl[i].idle, tbl[i].ulps);
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), int'(obs), int'(tbl[i].exp));
    end

    // Bring-up with a slow Stopstate
    do_reset();
    chk("reset_state", int'(obs), 0);
    lat = 5;
    t0 = cyc;
    set_in(1, 0, 0, 0);
    step(3);
    chk("enable_rise", rise[0], t0 + 1);
    step(14);
    chk("init_stop", int'(obs), 1);

    // HS burst, one-cycle release, then the STOP gap before the next burst
    lat = 3;
    step(12);
    t0 = cyc;
    hs_req = 1;
    step(8);
    chk("hs_req_rise", rise[1], t0 + 1);
    chk("hs_rdy_rise", rise[5], t0 + 1 + lat);
    t3 = cyc;
    hs_req = 0;
    step(1);
    hs_req = 1;
    step(20);
    chk("hs_req_fall", fall[1], t3 + 1);
    chk("stop_gap", rise[1], t3 + 1 + lat + GAP);

    // lane_en dropped in HS_ON and in ULPS_EXIT
    lane_en = 0;
    step(1);
    chk("off_from_hs_on", int'(obs), 0);
    set_in(1, 0, 0, 0);
    step(15);
    chk("reenable_stop", int'(obs), 1);
    ulps_req = 1;
    step(10);
    ulps_req = 0;
    step(10);
    chk("ulps_exit_state", int'(obs), 9'b000011001);
    lane_en = 0;
    step(1);
    chk("off_from_ulps_exit", int'(obs), 0);
    lane_en = 1;
    step(15);
    chk("reenable_stop2", int'(obs), 1);

    // Acknowledge timeout
    tie_rdy0 = 1'b1;
    t0 = cyc;
    hs_req = 1;
    step(TMO + 10);
    chk("tmo_err_rise", rise[8], t0 + 1 + TMO);
    chk("tmo_reqhs_fall", fall[1], t0 + 1 + TMO);
    chk("err_state", int'(obs), 9'b100000001);
    tie_rdy0 = 1'b0;
    set_in(0, 0, 0, 0);
    step(5);
    chk("err_sticky", int'(obs), 9'b100000000);
    do_reset();
    chk("err_cleared", int'(obs), 0);

    // Random episodes checked against latency arithmetic
    set_in(1, 0, 0, 0);
    step(15);
    for (int e = 0; e < 24; e++) begin
      step(16);
      lat = $urandom_range(1, 6);
      kind = $urandom_range(0, 3);
      t0 = cyc;
      if (kind < 3) begin
        hs_req = 1;
        step(lat + 3);
        chk("r_hs_req_rise", rise[1], t0 + 1);
        chk("r_hs_rdy_rise", rise[5], t0 + 1 + lat);
        if (kind > 0) begin
          step($urandom_range(1, 20));
          t1 = cyc;
          idle_req = 1;
          step(lat + 3);
          chk("r_idleclk_rise", rise[2], t1 + 1);
          chk("r_clk_idle_rise", rise[6], t1 + 1 + lat);
          chk("r_hs_rdy_drop", fall[5], t1 + 1);
          step($urandom_range(1, 200));
          t2 = cyc;
          idle_req = 0;
          step(12);
          chk("r_clk_idle_fall", fall[6], t2 + 1);
          chk("r_idleclk_fall", fall[2], t2 + 1);
          chk("r_idle_exit_gap", rise[5], t2 + 1 + (lat > GAP ? lat : GAP));
          chk("r_reqhs_held", int'(fall[1] < rise[1]), 1);
        end
        step($urandom_range(1, 30));
        t3 = cyc;
        hs_req = 0;
        step(3);
        chk("r_hs_req_fall", fall[1], t3 + 1);
        chk("r_hs_rdy_fall", fall[5], t3 + 1);
      end else begin
        ulps_req = 1;
        step(lat + 3);
        chk("r_ulpsclk_rise", rise[3], t0 + 1);
        chk("r_clk_ulps_rise", rise[7], t0 + 1 + lat);
        step($urandom_range(1, 20));
        t1 = cyc;
        ulps_req = 0;
        step(3);
        chk("r_clk_ulps_fall", fall[7], t1 + 1);
        chk("r_ulpsexit_rise", rise[4], t1 + 1);
        step(WAKE);
        chk("r_ulpsexit_fall", fall[4], t1 + 1 + WAKE);
        chk("r_ulpsclk_fall", fall[3], t1 + 1 + WAKE);
      end
    end
    step(16);
    chk("r_final_stop", int'(obs), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csi_clk_lane_ctrl.md
Name: csi_clk_lane_ctrl

Overview:
- Synthesizable PPI-side controller that sits directly upstream of the D-PHY Master Clock Lane (CIL-MCNN) and drives its PPI request signals.
- Accepts HS-clock, HS-Idle and ULPS requests from the CSI TX lane-management logic.
- Sequences the clock-lane PPI handshakes (TxRequestHS/TxReadyHS, TxHSIdleClkHS/TxHSIdleClkReadyHS, TxUlpsClk/TxUlpsExit/UlpsActiveNot).
- Reports a clean "clock running" status to the data-lane controllers.

Parameters:
- TIMEOUT_CYC, 4096, max cycles to wait for any PPI acknowledge before flagging an error.
- GAP_CYC, 8, minimum cycles in STOP between HS bursts, and between HS-Idle exit and the next HS-Idle entry.
- WAKEUP_CYC, 1000, cycles TxUlpsExit is held before TxUlpsClk is released (T_WAKEUP in word clocks).
- CNT_W, $clog2(TIMEOUT_CYC+1), width of the shared counter; must cover max(TIMEOUT_CYC, WAKEUP_CYC, GAP_CYC).

Ports:
- clk  in  1  TxWordClkHS-domain clock
- rst  in  1  asynchronous reset, active high
- lane_en  in  1  lane enable request from configuration
- hs_req  in  1  level: keep HS clock running
- idle_req  in  1  level: enter HS Tx Idle (valid only while HS clock is up)
- ulps_req  in  1  level: enter ULPS (valid only from STOP)
- clk_hs_rdy  out  1  HS clock running, data lanes may start HS
- clk_idle  out  1  clock lane is in HS Tx Idle
- clk_ulps  out  1  clock lane is in ULPS
- err  out  1  sticky error (timeout or illegal request)
- ppi_Enable  out  1  to PPI Enable
- ppi_TxRequestHS  out  1  to PPI
- ppi_TxHSIdleClkHS  out  1  to PPI
- ppi_TxUlpsClk  out  1  to PPI
- ppi_TxUlpsExit  out  1  to PPI
- ppi_Stopstate  in  1  from PPI
- ppi_TxReadyHS  in  1  from PPI
- ppi_TxHSIdleClkReadyHS  in  1  from PPI
- ppi_UlpsActiveNot  in  1  from PPI, active low

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All outputs are 0 on reset. State OFF, counter 0, err 0.
- All outputs are registered. A request is sampled at edge N; the corresponding PPI output changes at edge N+1.
- The counter is cleared on every state change. In every WAIT-type state it increments; on reaching TIMEOUT_CYC the FSM sets err and goes to ERR.
- States and transitions:
  - OFF: Enable=0. lane_en -> INIT.
  - INIT: Enable=1. Wait for Stopstate=1 -> STOP.
  - STOP: all requests low. Counter runs to GAP_CYC; requests are ignored until the gap has elapsed.
    - hs_req -> HS_REQ.
    - ulps_req -> ULPS_ENT.
    - hs_req and ulps_req together -> hs wins, err set, no state abort.
    - idle_req in STOP -> err set, request ignored.
  - HS_REQ: TxRequestHS=1. TxReadyHS=1 -> HS_ON.
  - HS_ON: clk_hs_rdy=1.
    - !hs_req -> HS_END.
    - idle_req -> IDLE_ENT.
    - Both at once -> HS_END (termination wins).
  - HS_END: TxRequestHS=0, clk_hs_rdy=0. TxReadyHS=0 and Stopstate=1 -> STOP.
  - IDLE_ENT: TxHSIdleClkHS=1, TxRequestHS held 1. TxHSIdleClkReadyHS=1 -> IDLE.
  - IDLE: clk_idle=1. !idle_req -> IDLE_EXIT.
  - IDLE_EXIT: TxHSIdleClkHS=0. TxHSIdleClkReadyHS=0 and TxReadyHS=1 -> HS_ON after GAP_CYC has elapsed. Ready condition met early -> remain in IDLE_EXIT until the gap expires.
  - ULPS_ENT: TxUlpsClk=1. UlpsActiveNot=0 -> ULPS.
  - ULPS: clk_ulps=1. !ulps_req -> ULPS_EXIT.
  - ULPS_EXIT: TxUlpsExit=1, TxUlpsClk=1. After WAKEUP_CYC cycles, both drop -> ULPS_WAIT.
  - ULPS_WAIT: Stopstate=1 and UlpsActiveNot=1 -> STOP.
  - ERR: all PPI requests 0, Enable held. Leaves only via !lane_en -> OFF, or rst.
- lane_en deasserted in any state: all PPI outputs go to 0 on the next edge, status outputs clear, state -> OFF. err is not cleared by this.
- err is sticky and clears only on rst.
- Counter saturates; it never wraps.

Decomposition:
- Shared package csi_ctrl_pkg holds:
  - typedef enum t_clk_ctrl_states (OFF, INIT, STOP, HS_REQ, HS_ON, HS_END, IDLE_ENT, IDLE, IDLE_EXIT, ULPS_ENT, ULPS, ULPS_EXIT, ULPS_WAIT, ERR);
  - default timing constants in word-clock cycles.
- One sub-module: csi_sat_cnt, a clearable saturating counter with a terminal-count compare, shared by the timeout, gap and wakeup functions.
- The bench pairs the block with the existing MCNN behavioural model via the PPI interface.

Test Plan:
- Reset, then lane_en=1 with Stopstate rising 5 cycles later -> Enable=1 one cycle after lane_en; STOP reached; all status outputs 0.
- hs_req=1 in STOP after the gap, model returns TxReadyHS -> TxRequestHS rises next edge; clk_hs_rdy=1 one cycle after TxReadyHS. hs_req=0 -> TxRequestHS=0 next edge; STOP on Stopstate.
- In HS_ON, idle_req=1 for 200 cycles -> TxHSIdleClkHS=1; clk_idle=1 after ReadyHS. On release, HS_ON is re-entered no earlier than 8 cycles later; TxRequestHS never drops.
- ulps_req=1 in STOP, then release -> TxUlpsClk=1; clk_ulps=1 on UlpsActiveNot=0. TxUlpsExit held exactly 1000 cycles, then both drop; STOP reached.
- TxReadyHS tied 0 with hs_req=1 -> err=1 at cycle 4096 after entering HS_REQ; TxRequestHS=0; err persists until rst.
- lane_en=0 mid HS_ON, and separately mid ULPS_EXIT -> all PPI outputs 0 next edge; state OFF; re-enable reaches STOP normally.
